seq_game_controller: RTL and testbench
======================================

SEQ_GAME_CONTROLLER -- requirements
Module: seq_game_controller

Interface
REQ-001 Parameter DATA_W, default 4, width of one sequence element (LED/button pattern).
REQ-002 Parameter N_ROUNDS, default 16, maximum sequence length; the final round shows N_ROUNDS elements.
REQ-003 Parameter T_SHOW, default 1000, cycles an element stays lit during playback.
REQ-004 Parameter T_GAP, default 500, cycles of blank display between elements.
REQ-005 Parameter T_PLAY, default 5000, cycles allowed per player entry before timeout.
REQ-006 Parameter N_LIVES, default 1, errors tolerated per game; N_LIVES=1 means the first error ends the game.
REQ-007 Derived AW = clog2(N_ROUNDS) SHALL size mem_addr and the internal round/element counters.
REQ-008 clock  input  1  single system clock, rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 iniciar  input  1  start/restart request, level-sampled.
REQ-011 mem_data  input  DATA_W  sequence ROM/RAM word at mem_addr, combinational read.
REQ-012 jogada  input  DATA_W  player pattern, valid only when jogada_valid=1.
REQ-013 jogada_valid  input  1  single-cycle pulse: one player entry.
REQ-014 mem_addr  output  AW  element index E.
REQ-015 leds  output  DATA_W  display pattern.
REQ-016 rodada  output  AW  current round index L (round shows L+1 elements).
REQ-017 vidas  output  clog2(N_LIVES+1)  remaining lives.
REQ-018 pronto / acertou / errou / timeout  output  1 each  game-end flags.
REQ-019 db_estado  output  4  state code for debug display.

Function
REQ-020 States, with db_estado codes: IDLE=0, PREP=1, INIT_SEQ=2, LOAD=3, SHOW=4, GAP=5, WAIT=6, CHECK=7, NEXT_ROUND=8, REPLAY=9, WIN=10, LOSE=11, TMO=12; any illegal state code SHALL recover to IDLE next cycle and drive db_estado=15.
REQ-021 IDLE: iniciar=1 -> PREP; otherwise hold.
REQ-022 PREP: L=0, E=0, timer=0, vidas=N_LIVES, leds=0; -> INIT_SEQ.
REQ-023 INIT_SEQ: E=0, timer=0; -> LOAD.
REQ-024 LOAD: display register <= mem_data, timer=0; -> SHOW.
REQ-025 SHOW: leds=display register; timer counts; at timer==T_SHOW-1 -> GAP with timer=0, so SHOW lasts exactly T_SHOW cycles.
REQ-026 GAP: leds=0; at timer==T_GAP-1: E<L -> LOAD with E=E+1; E==L -> WAIT with E=0, timer=0.
REQ-027 WAIT: leds=jogada when jogada_valid=1, else 0; timer counts.
- jogada_valid=1 -> capture jogada, -> CHECK.
- timer==T_PLAY-1 with no jogada_valid -> TMO.
- jogada_valid=1 in the same cycle as timer==T_PLAY-1: the entry wins, -> CHECK.
REQ-028 CHECK: captured jogada compared with mem_data at E.
- match, E<L -> WAIT with E=E+1, timer=0.
- match, E==L, L<N_ROUNDS-1 -> NEXT_ROUND.
- match, E==L, L==N_ROUNDS-1 -> WIN.
- mismatch, vidas>1 -> REPLAY with vidas=vidas-1.
- mismatch, vidas==1 -> LOSE with vidas=0.
REQ-029 NEXT_ROUND: L=L+1; -> INIT_SEQ.
REQ-030 REPLAY: L unchanged; -> INIT_SEQ, so the same round is shown again.
REQ-031 WIN / LOSE / TMO: pronto=1. WIN adds acertou=1; LOSE adds errou=1; TMO adds errou=1 and timeout=1. leds=0. iniciar=1 -> PREP; otherwise hold.
REQ-032 iniciar SHALL be ignored in every state other than IDLE, WIN, LOSE and TMO.
REQ-033 jogada_valid SHALL be ignored outside WAIT; a pulse arriving in CHECK SHALL be dropped and SHALL NOT be queued.
REQ-034 Counters never wrap: E≤L≤N_ROUNDS-1; timer saturates at its terminal count.
REQ-035 All outputs SHALL be registered or decoded from state/registers only (Moore); no combinational path from inputs to outputs, except leds echoing jogada in WAIT.

Reset
REQ-036 reset=0 forces IDLE asynchronously: L=E=timer=0, vidas=N_LIVES, leds=0, pronto=acertou=errou=timeout=0, db_estado=0.
REQ-037 reset asserted mid-playback or mid-entry SHALL abort immediately, with no residual flags after release.
REQ-038 After reset release, the first state change SHALL occur on the first rising clock edge with iniciar=1.

Verification
Bench parameters: N_ROUNDS=4, T_SHOW=3, T_GAP=2, T_PLAY=10, N_LIVES=2; ROM = {1,2,4,8}.
REQ-039 Perfect game, all 10 entries correct -> WIN, acertou=1, rodada=3; each SHOW lasts 3 cycles and each GAP 2 cycles.
REQ-040 Round 2, second entry = 4 (expected 2) -> REPLAY, vidas=1, rodada=1, playback of {1,2} again; a second error -> LOSE, errou=1, vidas=0.
REQ-041 No entry for 10 cycles in WAIT -> TMO with pronto=errou=timeout=1; entry pulsed on cycle 10 instead -> CHECK, no timeout.
REQ-042 jogada_valid pulsed during SHOW and in CHECK -> ignored; the state sequence and E are unchanged.
REQ-043 reset=0 during GAP of round 3 -> IDLE in the same cycle, all outputs at reset values; iniciar -> new game from rodada=0, vidas=2.

Source files
------------

// File: rtl/seq_game_controller_if.sv
// Bundle between the sequence-game controller and its board:
// start request, player entry, sequence memory port and status/display outputs.
interface seq_game_controller_if #(
    parameter int DATA_W   = 4,
    parameter int N_ROUNDS = 16,
    parameter int N_LIVES  = 1
);
    localparam int AW = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;
    localparam int VW = (N_LIVES > 0) ? $clog2(N_LIVES + 1) : 1;

    logic              iniciar;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] jogada;
    logic              jogada_valid;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] leds;
    logic [AW-1:0]     rodada;
    logic [VW-1:0]     vidas;
    logic              pronto;
    logic              acertou;
    logic              errou;
    logic              timeout;
    logic [3:0]        db_estado;

    // Controller side.
    modport master (
        input  iniciar, mem_data, jogada, jogada_valid,
        output mem_addr, leds, rodada, vidas,
        output pronto, acertou, errou, timeout, db_estado
    );

    // Board / environment side.
    modport slave (
        output iniciar, mem_data, jogada, jogada_valid,
        input  mem_addr, leds, rodada, vidas,
        input  pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/seq_game_controller.sv
// Memory-sequence game controller: plays back a growing sequence, checks player
// entries, tracks lives and timeouts. Ports: clock, reset (async, active-low), bus.
module seq_game_controller #(
    parameter int DATA_W   = 4,
    parameter int N_ROUNDS = 16,
    parameter int T_SHOW   = 1000,
    parameter int T_GAP    = 500,
    parameter int T_PLAY   = 5000,
    parameter int N_LIVES  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    seq_game_controller_if.master bus
);
    localparam int AW   = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;
    localparam int VW   = (N_LIVES > 0) ? $clog2(N_LIVES + 1) : 1;
    localparam int TMX1 = (T_SHOW > T_GAP) ? T_SHOW : T_GAP;
    localparam int TMAX = (TMX1 > T_PLAY) ? TMX1 : T_PLAY;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SHOW_END = TW'(T_SHOW - 1);
    localparam logic [TW-1:0] GAP_END  = TW'(T_GAP - 1);
    localparam logic [TW-1:0] PLAY_END = TW'(T_PLAY - 1);
    localparam logic [AW-1:0] LAST_RND = AW'(N_ROUNDS - 1);
    localparam logic [VW-1:0] LIVES0   = VW'(N_LIVES);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        PREP       = 4'd1,
        INIT_SEQ   = 4'd2,
        LOAD       = 4'd3,
        SHOW       = 4'd4,
        GAP        = 4'd5,
        WAIT       = 4'd6,
        CHECK      = 4'd7,
        NEXT_ROUND = 4'd8,
        REPLAY     = 4'd9,
        WIN        = 4'd10,
        LOSE       = 4'd11,
        TMO        = 4'd12
    } state_t;

    state_t            state, stateN;
    logic [AW-1:0]     lvl, lvlN;
    logic [AW-1:0]     elem, elemN;
    logic [TW-1:0]     timer, timerN, timerInc;
    logic [VW-1:0]     vidasQ, vidasN;
    logic [DATA_W-1:0] disp, dispN;
    logic [DATA_W-1:0] cap, capN;

    // Saturating increment; terminal counts always leave the state first.
    assign timerInc = (timer == {TW{1'b1}}) ? timer : timer + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            lvl    <= '0;
            elem   <= '0;
            timer  <= '0;
            vidasQ <= LIVES0;
            disp   <= '0;
            cap    <= '0;
        end else begin
            state  <= stateN;
            lvl    <= lvlN;
            elem   <= elemN;
            timer  <= timerN;
            vidasQ <= vidasN;
            disp   <= dispN;
            cap    <= capN;
        end
    end

    always_comb begin
        stateN = state;
        lvlN   = lvl;
        elemN  = elem;
        timerN = timer;
        vidasN = vidasQ;
        dispN  = disp;
        capN   = cap;
        case (state)
            IDLE: begin
                if (bus.iniciar) stateN = PREP;
            end
            PREP: begin
                lvlN   = '0;
                elemN  = '0;
                timerN = '0;
                vidasN = LIVES0;
                dispN  = '0;
                stateN = INIT_SEQ;
            end
            INIT_SEQ: begin
                elemN  = '0;
                timerN = '0;
                stateN = LOAD;
            end
            LOAD: begin
                dispN  = bus.mem_data;
                timerN = '0;
                stateN = SHOW;
            end
            SHOW: begin
                if (timer == SHOW_END) begin
                    timerN = '0;
                    stateN = GAP;
                end else begin
                    timerN = timerInc;
                end
            end
            GAP: begin
                if (timer == GAP_END) begin
                    timerN = '0;
                    if (elem < lvl) begin
                        elemN  = elem + 1'b1;
                        stateN = LOAD;
                    end else begin
                        elemN  = '0;
                        stateN = WAIT;
                    end
                end else begin
                    timerN = timerInc;
                end
            end
            WAIT: begin
                // An entry on the last allowed cycle still counts.
                if (bus.jogada_valid) begin
                    capN   = bus.jogada;
                    stateN = CHECK;
                end else if (timer == PLAY_END) begin
                    stateN = TMO;
                end else begin
                    timerN = timerInc;
                end
            end
            CHECK: begin
                if (cap == bus.mem_data) begin
                    if (elem < lvl) begin
                        elemN  = elem + 1'b1;
                        timerN = '0;
                        stateN = WAIT;
                    end else if (lvl < LAST_RND) begin
                        stateN = NEXT_ROUND;
                    end else begin
                        stateN = WIN;
                    end
                end else if (vidasQ > VW'(1)) begin
                    vidasN = vidasQ - 1'b1;
                    stateN = REPLAY;
                end else begin
                    vidasN = '0;
                    stateN = LOSE;
                end
            end
            NEXT_ROUND: begin
                if (lvl < LAST_RND) lvlN = lvl + 1'b1;
                stateN = INIT_SEQ;
            end
            REPLAY: begin
                stateN = INIT_SEQ;
            end
            WIN, LOSE, TMO: begin
                if (bus.iniciar) stateN = PREP;
            end
            default: begin
                stateN = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.leds = '0;
        if (state == SHOW) begin
            bus.leds = disp;
        end else if (state == WAIT && bus.jogada_valid) begin
            bus.leds = bus.jogada;
        end
    end

    assign bus.mem_addr  = elem;
    assign bus.rodada    = lvl;
    assign bus.vidas     = vidasQ;
    assign bus.pronto    = (state == WIN) || (state == LOSE) || (state == TMO);
    assign bus.acertou   = (state == WIN);
    assign bus.errou     = (state == LOSE) || (state == TMO);
    assign bus.timeout   = (state == TMO);
    assign bus.db_estado = (state > TMO) ? 4'hF : 4'(state);
endmodule

// File: tb/tb_seq_game_controller.sv
// Directed bench for seq_game_controller: 4 rounds, ROM {1,2,4,8}, 2 lives.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_game_controller;
    localparam int DW = 4;
    localparam int NR = 4;
    localparam int TS = 3;
    localparam int TG = 2;
    localparam int TP = 10;
    localparam int NL = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] rom [0:3] = '{4'd1, 4'd2, 4'd4, 4'd8};

    seq_game_controller_if #(.DATA_W(DW), .N_ROUNDS(NR), .N_LIVES(NL)) bus ();

    seq_game_controller #(
        .DATA_W(DW), .N_ROUNDS(NR), .T_SHOW(TS),
        .T_GAP(TG), .T_PLAY(TP), .N_LIVES(NL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always_comb bus.mem_data = rom[bus.mem_addr];

    task automatic run_to(input logic [3:0] code, output bit ok);
        int n;
        n = 0;
        while (bus.db_estado !== code && n < 300) begin
            @(negedge clock);
            n++;
        end
        ok = (bus.db_estado === code);
    endtask

    task automatic start_game;
        bus.iniciar = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
    endtask

    task automatic enter(input logic [3:0] v);
        bus.jogada       = v;
        bus.jogada_valid = 1'b1;
        @(negedge clock);
        bus.jogada_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        @(negedge clock);
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", bus.db_estado); end
        checks++; if (bus.leds !== 4'd0) begin errors++; $display("FAIL rst_leds got=%0d exp=0", bus.leds); end
        checks++; if (bus.vidas !== 2'd2) begin errors++; $display("FAIL rst_vidas got=%0d exp=2", bus.vidas); end
        checks++; if (bus.rodada !== 2'd0 || bus.mem_addr !== 2'd0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", bus.rodada, bus.mem_addr); end
        checks++; if ({bus.pronto, bus.acertou, bus.errou, bus.timeout} !== 4'b0000) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {bus.pronto, bus.acertou, bus.errou, bus.timeout}); end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL idle_hold got=%0d exp=0", bus.db_estado); end
    endtask

    task automatic test_perfect_game;
        bit ok;
        int n;
        logic [3:0] exp;
        start_game;
        checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("FAIL prep got=%0d exp=1", bus.db_estado); end
        for (int l = 0; l < 4; l++) begin
            for (int e = 0; e <= l; e++) begin
                run_to(4'd4, ok);
                checks++; if (!ok) begin errors++; $display("FAIL reach_show got=%0d exp=4", bus.db_estado); end
                checks++; if (bus.leds !== rom[e] || bus.mem_addr !== 2'(e)) begin errors++; $display("FAIL show_leds got=%0d@%0d exp=%0d@%0d", bus.leds, bus.mem_addr, rom[e], e); end
                n = 0;
                while (bus.db_estado === 4'd4 && n < 50) begin n++; @(negedge clock); end
                checks++; if (n != TS) begin errors++; $display("FAIL show_len got=%0d exp=%0d", n, TS); end
                n = 0;
                while (bus.db_estado === 4'd5 && n < 50) begin n++; @(negedge clock); end
                checks++; if (n != TG) begin errors++; $display("FAIL gap_len got=%0d exp=%0d", n, TG); end
            end
            checks++; if (bus.db_estado !== 4'd6 || bus.rodada !== 2'(l)) begin errors++; $display("FAIL wait_rnd got=%0d/%0d exp=6/%0d", bus.db_estado, bus.rodada, l); end
            for (int e = 0; e <= l; e++) begin
                bus.jogada       = rom[e];
                bus.jogada_valid = 1'b1;
                #1;
                checks++; if (bus.leds !== rom[e]) begin errors++; $display("FAIL echo got=%0d exp=%0d", bus.leds, rom[e]); end
                @(negedge clock);
                bus.jogada_valid = 1'b0;
                checks++; if (bus.db_estado !== 4'd7) begin errors++; $display("FAIL check_st got=%0d exp=7", bus.db_estado); end
                @(negedge clock);
                exp = (e < l) ? 4'd6 : ((l < 3) ? 4'd8 : 4'd10);
                checks++; if (bus.db_estado !== exp) begin errors++; $display("FAIL after_check got=%0d exp=%0d", bus.db_estado, exp); end
            end
        end
        checks++; if ({bus.pronto, bus.acertou, bus.errou, bus.timeout} !== 4'b1100) begin errors++; $display("FAIL win_flags got=%b exp=1100", {bus.pronto, bus.acertou, bus.errou, bus.timeout}); end
        checks++; if (bus.rodada !== 2'd3 || bus.leds !== 4'd0) begin errors++; $display("FAIL win_out got=%0d/%0d exp=3/0", bus.rodada, bus.leds); end
    endtask

    task automatic test_replay_lose;
        bit ok;
        start_game;
        checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("FAIL restart_win got=%0d exp=1", bus.db_estado); end
        run_to(4'd6, ok);
        enter(4'd1);
        checks++; if (bus.db_estado !== 4'd8) begin errors++; $display("FAIL r0_next got=%0d exp=8", bus.db_estado); end
        run_to(4'd6, ok);
        enter(4'd1);
        checks++; if (bus.db_estado !== 4'd6 || bus.mem_addr !== 2'd1) begin errors++; $display("FAIL r1_e0 got=%0d/%0d exp=6/1", bus.db_estado, bus.mem_addr); end
        enter(4'd4);
        checks++; if (bus.db_estado !== 4'd9) begin errors++; $display("FAIL replay_st got=%0d exp=9", bus.db_estado); end
        checks++; if (bus.vidas !== 2'd1 || bus.rodada !== 2'd1) begin errors++; $display("FAIL replay_cnt got=%0d/%0d exp=1/1", bus.vidas, bus.rodada); end
        run_to(4'd4, ok);
        checks++; if (!ok || bus.leds !== 4'd1) begin errors++; $display("FAIL replay_e0 got=%0d exp=1", bus.leds); end
        run_to(4'd5, ok);
        run_to(4'd4, ok);
        checks++; if (!ok || bus.leds !== 4'd2) begin errors++; $display("FAIL replay_e1 got=%0d exp=2", bus.leds); end
        run_to(4'd6, ok);
        checks++; if (!ok || bus.mem_addr !== 2'd0) begin errors++; $display("FAIL replay_wait got=%0d exp=0", bus.mem_addr); end
        enter(4'd1);
        enter(4'd8);
        checks++; if (bus.db_estado !== 4'd11 || bus.vidas !== 2'd0) begin errors++; $display("FAIL lose got=%0d/%0d exp=11/0", bus.db_estado, bus.vidas); end
        checks++; if ({bus.pronto, bus.acertou, bus.errou, bus.timeout} !== 4'b1010) begin errors++; $display("FAIL lose_flags got=%b exp=1010", {bus.pronto, bus.acertou, bus.errou, bus.timeout}); end
    endtask

    task automatic test_timeout;
        bit ok;
        @(negedge clock);
        checks++; if (bus.db_estado !== 4'd11) begin errors++; $display("FAIL lose_hold got=%0d exp=11", bus.db_estado); end
        start_game;
        run_to(4'd6, ok);
        checks++; if (bus.vidas !== 2'd2) begin errors++; $display("FAIL new_vidas got=%0d exp=2", bus.vidas); end
        for (int i = 0; i < TP; i++) begin
            checks++; if (bus.db_estado !== 4'd6) begin errors++; $display("FAIL wait_cyc%0d got=%0d exp=6", i, bus.db_estado); end
            @(negedge clock);
        end
        checks++; if (bus.db_estado !== 4'd12) begin errors++; $display("FAIL tmo_st got=%0d exp=12", bus.db_estado); end
        checks++; if ({bus.pronto, bus.acertou, bus.errou, bus.timeout} !== 4'b1011) begin errors++; $display("FAIL tmo_flags got=%b exp=1011", {bus.pronto, bus.acertou, bus.errou, bus.timeout}); end
        @(negedge clock);
        checks++; if (bus.db_estado !== 4'd12 || bus.leds !== 4'd0) begin errors++; $display("FAIL tmo_hold got=%0d/%0d exp=12/0", bus.db_estado, bus.leds); end
        start_game;
        run_to(4'd6, ok);
        repeat (TP - 1) @(negedge clock);
        checks++; if (bus.db_estado !== 4'd6) begin errors++; $display("FAIL last_cyc got=%0d exp=6", bus.db_estado); end
        bus.jogada       = 4'd1;
        bus.jogada_valid = 1'b1;
        @(negedge clock);
        bus.jogada_valid = 1'b0;
        checks++; if (bus.db_estado !== 4'd7) begin errors++; $display("FAIL late_entry got=%0d exp=7", bus.db_estado); end
        @(negedge clock);
        checks++; if (bus.db_estado !== 4'd8 || bus.timeout !== 1'b0) begin errors++; $display("FAIL late_next got=%0d/%0d exp=8/0", bus.db_estado, bus.timeout); end
    endtask

    task automatic test_ignore;
        bit ok;
        run_to(4'd4, ok);
        bus.jogada       = 4'd8;
        bus.jogada_valid = 1'b1;
        bus.iniciar      = 1'b1;
        @(negedge clock);
        bus.jogada_valid = 1'b0;
        bus.iniciar      = 1'b0;
        checks++; if (bus.db_estado !== 4'd4 || bus.mem_addr !== 2'd0 || bus.leds !== 4'd1) begin errors++; $display("FAIL ign_show got=%0d/%0d/%0d exp=4/0/1", bus.db_estado, bus.mem_addr, bus.leds); end
        run_to(4'd5, ok);
        run_to(4'd4, ok);
        checks++; if (bus.leds !== 4'd2 || bus.mem_addr !== 2'd1) begin errors++; $display("FAIL ign_e1 got=%0d@%0d exp=2@1", bus.leds, bus.mem_addr); end
        run_to(4'd6, ok);
        bus.jogada       = 4'd1;
        bus.jogada_valid = 1'b1;
        @(negedge clock);
        checks++; if (bus.db_estado !== 4'd7) begin errors++; $display("FAIL ign_chk got=%0d exp=7", bus.db_estado); end
        bus.jogada = 4'd4;
        @(negedge clock);
        bus.jogada_valid = 1'b0;
        checks++; if (bus.db_estado !== 4'd6 || bus.mem_addr !== 2'd1) begin errors++; $display("FAIL ign_drop got=%0d/%0d exp=6/1", bus.db_estado, bus.mem_addr); end
        @(negedge clock);
        checks++; if (bus.db_estado !== 4'd6) begin errors++; $display("FAIL ign_noqueue got=%0d exp=6", bus.db_estado); end
        enter(4'd2);
        checks++; if (bus.db_estado !== 4'd8 || bus.vidas !== 2'd2) begin errors++; $display("FAIL ign_next got=%0d/%0d exp=8/2", bus.db_estado, bus.vidas); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        run_to(4'd4, ok);
        checks++; if (bus.rodada !== 2'd2) begin errors++; $display("FAIL r2_rnd got=%0d exp=2", bus.rodada); end
        run_to(4'd5, ok);
        reset = 1'b0;
        #1;
        checks++; if (bus.db_estado !== 4'd0 || bus.leds !== 4'd0) begin errors++; $display("FAIL mid_rst got=%0d/%0d exp=0/0", bus.db_estado, bus.leds); end
        checks++; if (bus.rodada !== 2'd0 || bus.mem_addr !== 2'd0 || bus.vidas !== 2'd2) begin errors++; $display("FAIL mid_cnt got=%0d/%0d/%0d exp=0/0/2", bus.rodada, bus.mem_addr, bus.vidas); end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (bus.db_estado !== 4'd0 || bus.pronto !== 1'b0) begin errors++; $display("FAIL post_rst got=%0d/%0d exp=0/0", bus.db_estado, bus.pronto); end
        start_game;
        checks++; if (bus.db_estado !== 4'd1) begin errors++; $display("FAIL post_start got=%0d exp=1", bus.db_estado); end
        run_to(4'd4, ok);
        checks++; if (bus.rodada !== 2'd0 || bus.vidas !== 2'd2 || bus.leds !== 4'd1) begin errors++; $display("FAIL new_game got=%0d/%0d/%0d exp=0/2/1", bus.rodada, bus.vidas, bus.leds); end
        run_to(4'd6, ok);
        bus.jogada       = 4'd1;
        bus.jogada_valid = 1'b1;
        #1 reset = 1'b0;
        #1;
        checks++; if (bus.db_estado !== 4'd0 || bus.leds !== 4'd0) begin errors++; $display("FAIL entry_rst got=%0d/%0d exp=0/0", bus.db_estado, bus.leds); end
        bus.jogada_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if ({bus.pronto, bus.acertou, bus.errou, bus.timeout} !== 4'b0000 || bus.db_estado !== 4'd0) begin errors++; $display("FAIL entry_post got=%b/%0d exp=0000/0", {bus.pronto, bus.acertou, bus.errou, bus.timeout}, bus.db_estado); end
    endtask

    initial begin
        bus.iniciar      = 1'b0;
        bus.jogada       = 4'd0;
        bus.jogada_valid = 1'b0;
        test_reset;
        test_perfect_game;
        test_replay_lose;
        test_timeout;
        test_ignore;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
